fifo_wr_burst_arbiter: RTL
==========================

Name: fifo_wr_burst_arbiter

Overview:
- Shares the single write port of the async-count FIFO among NUM_REQ valid/ready stream requesters in the wr_clk domain.
- Grants are round-robin, in bursts of up to MAX_BURST words.
- A burst is granted only when the FIFO's write-side count guarantees room for the whole burst.
- Each FIFO word carries {source id, last, data}, so the read side can demultiplex.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 16: payload width per requester.
- ADDR_WIDTH, 4: address width of the attached FIFO; depth is 2^ADDR_WIDTH.
- MAX_BURST, 4: maximum words per grant; must satisfy 1 <= MAX_BURST <= 2^ADDR_WIDTH.
- IDLE_TIMEOUT, 8: consecutive no-valid cycles inside a burst before the grant is revoked; 0 disables the timeout.
- ID_WIDTH (localparam): max(1, clog2(NUM_REQ)).
- FIFO_WIDTH (localparam): ID_WIDTH + 1 + DATA_WIDTH.

Ports:
- wr_clk  in  1  FIFO write clock.
- wr_rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  arbitration enable; when low, no new grants are issued and an active burst runs to completion.
- s_valid  in  NUM_REQ  per-requester valid.
- s_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_last  in  NUM_REQ  per-requester end-of-packet marker.
- s_ready  out  NUM_REQ  per-requester ready.
- fifo_wr_data  out  FIFO_WIDTH  {grant_id, s_last[sel], s_data[sel]}.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag.
- fifo_count_wr_clk  in  ADDR_WIDTH+1  FIFO occupancy as seen in the write domain.
- grant_valid  out  1  high while in the BURST state.
- grant_id  out  ID_WIDTH  currently granted requester.
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (asynchronous assertion):
  - State = IDLE; rr_ptr = 0; sel = 0; burst_cnt = 0; idle_cnt = 0.
  - All outputs are 0 (s_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, timeout_pulse).
  - Reset mid-burst aborts the burst immediately. No partial-packet marker is written.
- Free-space arithmetic:
  - free = 2^ADDR_WIDTH - fifo_count_wr_clk, computed in ADDR_WIDTH+1 bits (range 0..2^ADDR_WIDTH).
  - The count is pessimistic because the read pointer lags, so a granted burst can never overflow the FIFO.
- IDLE state:
  - s_ready = 0.
  - If en and |s_valid and free >= MAX_BURST: pick the first valid requester at or after rr_ptr, cyclically (the rr_pick sub-module).
  - Register the pick as sel, clear burst_cnt and idle_cnt, and go to BURST.
  - No transfer occurs in the IDLE cycle, so grant latency is 1 cycle from valid to ready.
- BURST state:
  - s_ready[i] = (i == sel) & !fifo_full, combinational.
  - xfer = s_valid[sel] & s_ready[sel].
  - fifo_wr_en = xfer, combinational, same cycle as the handshake.
  - fifo_wr_data is driven from sel every cycle; it is valid when fifo_wr_en is high.
  - On xfer: burst_cnt++ and idle_cnt = 0.
  - On !s_valid[sel]: idle_cnt++.
  - Exit to IDLE when any of the following holds:
    - xfer & s_last[sel];
    - xfer & burst_cnt == MAX_BURST-1 (forced split; the stored last bit stays 0);
    - IDLE_TIMEOUT != 0 and idle_cnt == IDLE_TIMEOUT-1 and !s_valid[sel]. This exit also pulses timeout_pulse.
  - On every exit: rr_ptr = (sel+1) mod NUM_REQ, which gives fairness.
- Back-to-back: exit to IDLE and re-grant cost exactly one dead cycle per burst.
- Simultaneous events: last on the MAX_BURST-th word counts as a single exit. en falling during BURST has no effect until the exit.
- fifo_full high during BURST stalls the burst and does not count as idle. This is unreachable when the free-space rule holds; it is kept as a safety gate.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST};
  - clog2-based ID width function;
  - FIFO_WIDTH computation helper.
- One sub-module, rr_pick:
  - Purely combinational.
  - Inputs: req vector and rr_ptr. Outputs: found and idx.
  - Implemented as a rotate, priority encode, then un-rotate.

Test Plan:
- Single requester 0 sends 3 words, last on word 3, fifo count 0:
  - s_ready[0] rises 1 cycle after s_valid.
  - 3 fifo_wr_en pulses with data {0, last, d}; last bit set only on word 3.
  - Then IDLE.
- Requesters 0..3 all valid, 8-word packets, MAX_BURST=4:
  - Grant order is 0,1,2,3,0,1,2,3.
  - Each burst is 4 words, and the 4th word has last=0 on the first pass.
  - One dead cycle between bursts.
- fifo_count_wr_clk=13 (free=3 < 4) with requester 2 valid: no grant. Drive count to 12: grant to requester 2 on the next cycle.
- Requester 1 granted, sends 1 word, then drops valid, IDLE_TIMEOUT=8:
  - timeout_pulse fires 8 cycles after the drop.
  - Next grant goes to requester 2 if it is valid.
- Assert wr_rst_n low mid-burst after word 2 of 4:
  - Outputs are 0 immediately, asynchronously.
  - After release, the first grant is to requester 0 (rr_ptr = 0).
- en=0 while requester 3 is mid-burst: the burst completes (all 4 words). No new grant while en=0; a grant follows the first cycle en=1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fifo_arb_pkg                                                 |
// | Description : Shared types and width helpers for the FIFO write-port burst |
// |               arbiter (state encoding, requester-id width, word width).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fifo_arb_pkg;

  // Arbiter control state, explicitly one bit wide.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Requester-id width: clog2 of the requester count, never less than one bit.
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // FIFO word layout is {source id, last, data}.
  function automatic int fifo_width(input int id_w, input int data_w);
    return id_w + 1 + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                      |
// | Description : Combinational round-robin picker. Returns the first asserted |
// |               request at or after rr_ptr, searching cyclically.            |
// | Ports       : req    - request vector                                      |
// |               rr_ptr - search start position                               |
// |               found  - any request asserted                                |
// |               idx    - index of the chosen request                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_WIDTH-1:0]  w_off;
  logic [ID_WIDTH:0]    w_sum;

  // Rotate so that position rr_ptr lands on bit 0.
  assign w_req_dbl = {req, req};
  assign w_rot     = w_req_dbl[rr_ptr +: NUM_REQ];

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = ID_WIDTH'(i);
      end
    end
  end

  // Un-rotate: (rr_ptr + offset) mod NUM_REQ, one extra bit holds the carry.
  assign w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
  assign idx   = (w_sum >= (ID_WIDTH+1)'(NUM_REQ)) ?
                 ID_WIDTH'(w_sum - (ID_WIDTH+1)'(NUM_REQ)) : w_sum[ID_WIDTH-1:0];
  assign found = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_burst_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_wr_burst_arbiter                                        |
// | Description : Shares one FIFO write port among NUM_REQ valid/ready streams.|
// |               Round-robin grants of up to MAX_BURST words, issued only     |
// |               when the write-side count guarantees room for a full burst.  |
// | Ports       : wr_clk, wr_rst_n    - write clock, async active-low reset    |
// |               en                  - allow new grants                       |
// |               s_valid/s_data/     - requester streams                      |
// |               s_last/s_ready                                               |
// |               fifo_wr_data/_en    - FIFO write port {id, last, data}       |
// |               fifo_full,          - FIFO status in write domain            |
// |               fifo_count_wr_clk                                            |
// |               grant_valid/_id     - current grant                          |
// |               timeout_pulse       - grant revoked after idle timeout       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_wr_burst_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 16,
  parameter  int ADDR_WIDTH   = 4,
  parameter  int MAX_BURST    = 4,
  parameter  int IDLE_TIMEOUT = 8,
  localparam int ID_WIDTH     = id_width(NUM_REQ),
  localparam int FIFO_WIDTH   = fifo_width(ID_WIDTH, DATA_WIDTH)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic [FIFO_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic [ADDR_WIDTH:0]           fifo_count_wr_clk,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          timeout_pulse
);

  localparam int c_cnt_w  = ADDR_WIDTH + 1;
  localparam int c_idle_w = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT);

  localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(2**ADDR_WIDTH);
  localparam logic [c_cnt_w-1:0]  c_max_burst = c_cnt_w'(MAX_BURST);
  localparam logic [c_cnt_w-1:0]  c_burst_end = c_cnt_w'(MAX_BURST - 1);
  localparam logic [c_idle_w-1:0] c_idle_end  = c_idle_w'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [ID_WIDTH-1:0] c_last_id   = ID_WIDTH'(NUM_REQ - 1);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [ID_WIDTH-1:0]   r_sel;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [c_cnt_w-1:0]    r_burst_cnt;
  logic [c_idle_w-1:0]   r_idle_cnt;

  logic [c_cnt_w-1:0]    w_free;
  logic                  w_pick_found;
  logic [ID_WIDTH-1:0]   w_pick_idx;
  logic                  w_start;
  logic                  w_xfer;
  logic                  w_timeout;
  logic                  w_exit;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // The count lags reads, so this free figure is never optimistic.
  assign w_free = c_depth - fifo_count_wr_clk;

  assign w_sel_valid = s_valid[r_sel];
  assign w_sel_last  = s_last[r_sel];
  assign w_sel_data  = s_data[r_sel*DATA_WIDTH +: DATA_WIDTH];

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (s_valid),
    .rr_ptr (r_rr_ptr),
    .found  (w_pick_found),
    .idx    (w_pick_idx)
  );

  // State register.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_xfer      = 1'b0;
    w_timeout   = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && w_pick_found && (w_free >= c_max_burst)) begin
          w_start     = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        w_xfer    = w_sel_valid && !fifo_full;
        // A full-FIFO stall holds valid high, so it never counts as idle.
        w_timeout = (IDLE_TIMEOUT != 0) && !w_sel_valid && (r_idle_cnt == c_idle_end);
        // Last on the final allowed word is one exit, not two.
        w_exit    = (w_xfer && (w_sel_last || (r_burst_cnt == c_burst_end))) || w_timeout;
        if (w_exit) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping: selected source, burst/idle counters, fairness pointer.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else if (w_start) begin
      r_sel       <= w_pick_idx;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else if (r_state == BURST) begin
      if (w_xfer) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
        r_idle_cnt  <= '0;
      end else if (!w_sel_valid) begin
        r_idle_cnt  <= r_idle_cnt + 1'b1;
      end
      if (w_exit) begin
        r_rr_ptr <= (r_sel == c_last_id) ? '0 : r_sel + 1'b1;
      end
    end
  end

  // Outputs: everything is quiet outside BURST, including during reset.
  always_comb begin
    s_ready       = '0;
    fifo_wr_en    = 1'b0;
    fifo_wr_data  = '0;
    grant_valid   = 1'b0;
    grant_id      = '0;
    timeout_pulse = 1'b0;
    if (r_state == BURST) begin
      s_ready[r_sel] = !fifo_full;
      fifo_wr_en     = w_xfer;
      fifo_wr_data   = {r_sel, w_sel_last, w_sel_data};
      grant_valid    = 1'b1;
      grant_id       = r_sel;
      timeout_pulse  = w_timeout;
    end
  end

endmodule
`default_nettype wire
